// File: rtl/isdft_reader.sv
// Inverse sliding-DFT reader: weights every bin of a framed spectrum block
// by a ROM coefficient and resynthesises one rounded, saturated sample.
module isdft_reader #(
    parameter int N     = 4096,
    parameter int AW    = $clog2(N),
    parameter int IW    = 32,
    parameter int CW    = 16,
    parameter int DW    = 16,
    parameter int SHIFT = AW + CW - 1,
    parameter int ACCW  = IW + CW + AW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2*IW-1:0] data_i,
    input  logic            sob_i,
    input  logic            eob_i,
    input  logic            valid_i,
    output logic [AW-1:0]   rdaddr_o,
    input  logic [2*CW-1:0] rddata_i,
    output logic [DW-1:0]   data_o,
    output logic            valid_o,
    output logic            sat_o,
    output logic            proto_err_o
);

    localparam int PW = IW + CW + 1;
    localparam int RW = ACCW + 1 - SHIFT;
    localparam logic [ACCW:0] HALF =
        {{(ACCW + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       idx;
    logic                take;
    logic                at_last;
    logic                done;
    logic                err;

    logic                s1_v, s1_first, s1_last;
    logic signed [IW-1:0] s1_re, s1_im;
    logic signed [CW-1:0] c_re, c_im;
    logic signed [PW-1:0] mr, mi;

    logic                s2_v, s2_first, s2_last;
    logic signed [PW-1:0] s2_p;

    logic signed [ACCW-1:0] acc;
    logic                a_last;

    logic signed [RW-1:0] r;
    logic                hi, lo;

    always_comb begin
        idx     = sob_i ? '0 : cnt;
        take    = valid_i && (sob_i || state == ACCUM);
        at_last = (idx == AW'(N - 1));
        done    = take && eob_i && at_last;
        err     = valid_i && ((state == IDLE && !sob_i)
                           || (state == ACCUM && sob_i)
                           || (take && (eob_i != at_last)));
    end

    assign rdaddr_o = idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            proto_err_o <= 1'b0;
        end else begin
            proto_err_o <= err;
            if (take) begin
                if (eob_i || at_last) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    state <= ACCUM;
                    cnt   <= idx + 1'b1;
                end
            end
        end
    end

    assign c_re = rddata_i[CW-1:0];
    assign c_im = rddata_i[2*CW-1:CW];
    assign mr   = PW'(s1_re) * PW'(c_re);
    assign mi   = PW'(s1_im) * PW'(c_im);

    // Only the completing beat carries s*_last, so dropped blocks never emit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_p     <= '0;
            acc      <= '0;
            a_last   <= 1'b0;
        end else begin
            s1_v     <= take;
            s1_first <= sob_i;
            s1_last  <= done;
            if (take) begin
                s1_re <= data_i[IW-1:0];
                s1_im <= data_i[2*IW-1:IW];
            end
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            if (s1_v)
                s2_p <= mr - mi;
            if (s2_v)
                acc <= s2_first ? ACCW'(s2_p) : acc + ACCW'(s2_p);
            a_last <= s2_v && s2_last;
        end
    end

    assign r  = RW'(($signed({acc[ACCW-1], acc}) + $signed(HALF)) >>> SHIFT);
    assign hi = !r[RW-1] && (|r[RW-2:DW-1]);
    assign lo = r[RW-1] && !(&r[RW-2:DW-1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= a_last;
            if (a_last) begin
                data_o <= hi ? {1'b0, {(DW-1){1'b1}}}
                        : lo ? {1'b1, {(DW-1){1'b0}}}
                        : r[DW-1:0];
                sat_o  <= hi || lo;
            end
        end
    end

endmodule

// File: tb/tb_isdft_reader.sv
// Directed bench for isdft_reader (N=8): scoreboard of expected samples
// pushed at eob and popped when valid_o fires.
module tb_isdft_reader;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int IW = 32;
    localparam int CW = 16;
    localparam int DW = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [2*IW-1:0] data_i = '0;
    logic            sob_i = 1'b0;
    logic            eob_i = 1'b0;
    logic            valid_i = 1'b0;
    logic [AW-1:0]   rdaddr_o;
    logic [2*CW-1:0] rddata_i = '0;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            sat_o;
    logic            proto_err_o;

    always #5 clk_i = ~clk_i;

    isdft_reader #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .sob_i       (sob_i),
        .eob_i       (eob_i),
        .valid_i     (valid_i),
        .rdaddr_o    (rdaddr_o),
        .rddata_i    (rddata_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .sat_o       (sat_o),
        .proto_err_o (proto_err_o)
    );

    logic signed [CW-1:0] cre [N];
    logic signed [CW-1:0] cim [N];
    logic signed [IW-1:0] bre [N];
    logic signed [IW-1:0] bim [N];

    always @(posedge clk_i) rddata_i <= {cim[rdaddr_o], cre[rdaddr_o]};

    typedef struct {
        longint d;
        longint s;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    int   pcount = 0;
    int   p0, v0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (proto_err_o) pcount++;
            if (valid_o) begin
                vcount++;
                if (q.size() == 0) begin
                    chk("queue_pending", q.size(), 1);
                end else begin
                    mon_e = q.pop_front();
                    chk("sample", longint'($signed(data_o)), mon_e.d);
                    chk("sat", longint'(sat_o), mon_e.s);
                end
            end
        end
    end

    function automatic exp_t model();
        longint acc;
        longint r;
        exp_t   e;
        acc = 0;
        for (int k = 0; k < N; k++)
            acc += longint'(bre[k]) * longint'(cre[k])
                 - longint'(bim[k]) * longint'(cim[k]);
        r = (acc + (longint'(1) <<< 17)) >>> 18;
        if (r > 32767) begin
            e.d = 32767; e.s = 1;
        end else if (r < -32768) begin
            e.d = -32768; e.s = 1;
        end else begin
            e.d = r; e.s = 0;
        end
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic beat(input logic s, input logic e, input int k);
        data_i  = {bim[k], bre[k]};
        sob_i   = s;
        eob_i   = e;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        sob_i   = 1'b0;
        eob_i   = 1'b0;
    endtask

    task automatic block(input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) idle(int'($urandom_range(1)));
            if (k == N - 1) q.push_back(model());
            beat(k == 0, k == N - 1, k);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 30) begin
            idle(1);
            t++;
        end
        chk("drain", q.size(), 0);
        idle(2);
    endtask

    task automatic set_bins(input logic signed [IW-1:0] re,
                            input logic signed [IW-1:0] im);
        for (int k = 0; k < N; k++) begin
            bre[k] = re;
            bim[k] = im;
        end
    endtask

    task automatic set_coef(input logic signed [CW-1:0] cr,
                            input logic signed [CW-1:0] ci);
        for (int k = 0; k < N; k++) begin
            cre[k] = cr;
            cim[k] = ci;
        end
    endtask

    task automatic rand_bins();
        for (int k = 0; k < N; k++) begin
            bre[k] = int'($urandom_range(2097152)) - 1048576;
            bim[k] = int'($urandom_range(2097152)) - 1048576;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        set_coef(16'sd32767, 16'sd0);
        set_bins(32'sd1000, 32'sd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", longint'(data_o), 0);
        chk("rst_valid", longint'(valid_o), 0);
        chk("rst_sat", longint'(sat_o), 0);
        chk("rst_perr", longint'(proto_err_o), 0);
        chk("rst_addr", longint'(rdaddr_o), 0);
        rst_i = 1'b0;
        idle(2);

        // re=1000 against c_re=32767, plus eob-to-valid latency
        block(1'b0);
        idle(2);
        chk("lat_early", longint'(valid_o), 0);
        idle(1);
        chk("lat_hit", longint'(valid_o), 1);
        idle(1);
        chk("lat_pulse", longint'(valid_o), 0);
        drain();
        chk("re_data", longint'($signed(data_o)), 1000);
        chk("re_sat", longint'(sat_o), 0);

        set_coef(16'sd0, -16'sd32768);
        set_bins(32'sd0, 32'sd1000);
        block(1'b0);
        drain();
        chk("im_pos", longint'($signed(data_o)), 1000);
        set_bins(32'sd0, -32'sd1000);
        block(1'b0);
        drain();
        chk("im_neg", longint'($signed(data_o)), -1000);

        set_coef(16'sd32767, 16'sd0);
        set_bins(32'sh4000_0000, 32'sd0);
        block(1'b0);
        drain();
        chk("sat_hi_data", longint'($signed(data_o)), 32767);
        chk("sat_hi_flag", longint'(sat_o), 1);
        set_bins(-32'sh4000_0000, 32'sd0);
        block(1'b0);
        drain();
        chk("sat_lo_data", longint'($signed(data_o)), -32768);
        chk("sat_lo_flag", longint'(sat_o), 1);

        // early eob on the fifth beat
        rand_bins();
        p0 = pcount;
        v0 = vcount;
        for (int k = 0; k < 5; k++) beat(k == 0, k == 4, k);
        idle(6);
        chk("e1_perr", pcount - p0, 1);
        chk("e1_noval", vcount - v0, 0);
        block(1'b0);
        drain();
        chk("e1_next", vcount - v0, 1);

        // sob on the third beat restarts the block
        rand_bins();
        p0 = pcount;
        v0 = vcount;
        beat(1'b1, 1'b0, 0);
        beat(1'b0, 1'b0, 1);
        block(1'b0);
        drain();
        chk("e2_perr", pcount - p0, 1);
        chk("e2_val", vcount - v0, 1);

        // stray beat while idle
        rand_bins();
        p0 = pcount;
        v0 = vcount;
        beat(1'b0, 1'b0, 3);
        idle(3);
        chk("e3_perr", pcount - p0, 1);
        chk("e3_noval", vcount - v0, 0);
        block(1'b0);
        drain();
        chk("e3_next", vcount - v0, 1);

        // three back-to-back blocks with random gaps and coefficients
        for (int k = 0; k < N; k++) begin
            cre[k] = 16'($urandom);
            cim[k] = 16'($urandom);
        end
        p0 = pcount;
        v0 = vcount;
        for (int b = 0; b < 3; b++) begin
            rand_bins();
            block(1'b1);
        end
        drain();
        chk("rnd_vals", vcount - v0, 3);
        chk("rnd_perr", pcount - p0, 0);

        // reset in the middle of a block
        set_coef(16'sd32767, 16'sd0);
        set_bins(32'sd1000, 32'sd0);
        v0 = vcount;
        for (int k = 0; k < 4; k++) beat(k == 0, 1'b0, k);
        data_i  = {bim[4], bre[4]};
        valid_i = 1'b1;
        rst_i   = 1'b1;
        #1;
        chk("mrst_data", longint'(data_o), 0);
        chk("mrst_valid", longint'(valid_o), 0);
        chk("mrst_sat", longint'(sat_o), 0);
        chk("mrst_perr", longint'(proto_err_o), 0);
        chk("mrst_addr", longint'(rdaddr_o), 0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        rst_i   = 1'b0;
        idle(6);
        chk("mrst_noval", vcount - v0, 0);
        block(1'b0);
        drain();
        chk("mrst_next", vcount - v0, 1);
        chk("mrst_data2", longint'($signed(data_o)), 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isdft_reader.md
Name: isdft_reader

Overview:
- Consumes the frequency-domain block stream emitted by the sliding DFT (sob/eob/valid framing, packed {im, re} bins) and reconstructs one time-domain sample per block.
- Computes a coefficient-weighted real sum over all N bins, then normalises, rounds and saturates it to DW bits.
- Sits downstream of the SDFT (optionally after spectral processing) and closes the analysis/resynthesis loop.
- Checks block framing and drops malformed blocks.

Parameters:
- N, 4096, bins per block.
- AW, $clog2(N), bin index / coefficient address width.
- IW, 32, width of each bin component (re, im).
- CW, 16, width of each coefficient component, signed Q1.(CW-1).
- DW, 16, output sample width.
- SHIFT, AW+CW-1, right shift applied to the accumulator before output.
- ACCW, IW+CW+AW+1, accumulator width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- data_i  in  2*IW  bin {im[2*IW-1:IW], re[IW-1:0]}, signed.
- sob_i  in  1  first bin of block, qualified by valid_i.
- eob_i  in  1  last bin of block, qualified by valid_i.
- valid_i  in  1  bin beat.
- rdaddr_o  out  AW  coefficient ROM address.
- rddata_i  in  2*CW  coefficient {c_im, c_re}; valid 1 clk after rdaddr_o.
- data_o  out  DW  reconstructed sample, signed.
- valid_o  out  1  one-cycle pulse when data_o is new.
- sat_o  out  1  saturation occurred on this sample; qualified by valid_o.
- proto_err_o  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, any state): FSM goes to IDLE; bin counter 0; pipeline valids cleared; data_o=0, valid_o=0, sat_o=0, proto_err_o=0, rdaddr_o=0. Reset mid-block discards the partial block with no output.
- FSM IDLE:
  - Beat with sob_i: accept as bin 0, go to ACCUM.
  - Beat without sob_i: ignored, proto_err_o pulses.
  - sob_i and eob_i together (N>1): error; stay IDLE.
- FSM ACCUM: each beat increments the bin counter. Cycles with valid_i low are gaps and are allowed; the block holds.
  - Beat with sob_i: proto_err_o pulses; partial block is discarded and this beat restarts as bin 0.
  - Beat with eob_i and counter==N-1: block completes; go to IDLE.
  - Beat with eob_i and counter!=N-1: proto_err_o pulses; block dropped; go to IDLE.
  - Beat at counter==N-1 without eob_i: proto_err_o pulses; block dropped; go to IDLE.
- Addressing: rdaddr_o is combinational, equal to 0 on a sob beat, else the bin counter.
- Pipeline, for a beat accepted in cycle t:
  - t+1: registered bin meets rddata_i. Product p = re*c_re - im*c_im, full precision IW+CW+1 bits, registered.
  - t+2: accumulator updated. Bin 0 loads p; later bins add p.
  - t+3: for the completing beat, r = (acc + 2^(SHIFT-1)) >>> SHIFT, saturated to signed DW and registered.
  - t+4: valid_o high for exactly one cycle with data_o and sat_o. data_o holds its value until the next valid_o.
- Eob-to-valid_o latency is 4 clocks.
- Throughput: one bin per clock, back-to-back blocks with no gap. The next sob beat may arrive in the cycle after eob; accumulator loading on bin 0 isolates blocks.
- A dropped block never asserts valid_o, even though its beats are already in the pipeline.
- Accumulator arithmetic is two's complement and does not overflow for ACCW as defined.

Test Plan:
- N=8, CW=16, SHIFT=18. Eight bins with re=1000, im=0 and coefficient {0, 32767} -> 4 clocks after eob: valid_o=1, data_o=1000, sat_o=0.
- Same N. re=0, im=1000, coefficient {-32768, 0} -> data_o=1000. Repeat with im=-1000 -> data_o=-1000.
- re=2^30 for all bins, coefficient {0, 32767} -> data_o=32767, sat_o=1. Negated input -> data_o=-32768, sat_o=1.
- Framing errors, each -> exactly one proto_err_o pulse and no valid_o for that block; the following well-formed block then gives a correct output:
  - eob asserted on the 5th beat.
  - sob asserted on the 3rd beat; the restarted block completes correctly with one valid_o.
  - valid_i beat while IDLE.
- Random valid_i gaps (about 50% duty) across three back-to-back blocks -> three valid_o pulses, each matching the reference sum bit-exactly.
- rst_i asserted mid-block on bin 4 -> all outputs 0 immediately, no valid_o; the next block reconstructs correctly.
